// File: rtl/paralelo_serial_tx_pkg.sv
//==============================================================================
// Module   : paralelo_serial_tx_pkg
// Brief    : Shared PHY serial-link constants and TX state encoding.
// Revision : 1.0
//==============================================================================
`default_nettype none

package paralelo_serial_tx_pkg;

    // The comma symbol and preamble length are also used by serial_paralelo_rx.
    localparam logic [7:0] COMMA_BC       = 8'hBC;
    localparam int         SYNC_COUNT_DEF = 4;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/paralelo_serial_tx_piso.sv
//==============================================================================
// Module   : paralelo_serial_tx_piso
// Brief    : Load/shift register with bit counter; MSB-first serial output.
// Revision : 1.0
//==============================================================================
`default_nettype none

module paralelo_serial_tx_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] load_word_i,
    output logic             boundary_o,
    output logic             serial_o
);

    localparam int              CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] bit_cnt_q;
    logic [WIDTH-2:0] shreg_q;
    logic             serial_q;

    // Counter resets to the last bit so the first edge after reset is a boundary.
    assign boundary_o = (bit_cnt_q == C_LAST);
    assign serial_o   = serial_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q <= C_LAST;
            shreg_q   <= '0;
            serial_q  <= 1'b0;
        end else if (boundary_o) begin
            serial_q  <= load_word_i[WIDTH-1];
            shreg_q   <= load_word_i[WIDTH-2:0];
            bit_cnt_q <= '0;
        end else begin
            serial_q  <= shreg_q[WIDTH-2];
            shreg_q   <= {shreg_q[WIDTH-3:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/paralelo_serial_tx.sv
//==============================================================================
// Module   : paralelo_serial_tx
// Brief    : PHY TX serializer: comma preamble, then valid/ready words MSB-first.
// Revision : 1.0
//==============================================================================
`default_nettype none

module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = COMMA_BC,
    parameter int               SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             active_out
);

    localparam int               CC_W        = $clog2(SYNC_COUNT + 1);
    localparam logic [CC_W-1:0]  C_LAST_SYNC = CC_W'(SYNC_COUNT - 1);

    tx_state_e        state_q;
    logic [CC_W-1:0]  comma_cnt_q;
    logic             active_q;
    logic             boundary;
    logic [WIDTH-1:0] word_d;

    assign ready_out  = (state_q == RUN) && boundary;
    assign active_out = active_q;

    // Idle fill: anything not handed over at a boundary goes out as a comma.
    always_comb begin
        word_d = COMMA;
        if (valid_in && ready_out) begin
            word_d = data_in;
        end
    end

    paralelo_serial_tx_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk_i       (clk_32f),
        .rst_ni      (reset_L),
        .load_word_i (word_d),
        .boundary_o  (boundary),
        .serial_o    (data_out)
    );

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= SYNC;
            comma_cnt_q <= '0;
            active_q    <= 1'b0;
        end else if (boundary) begin
            case (state_q)
                SYNC: begin
                    comma_cnt_q <= comma_cnt_q + 1'b1;
                    if (comma_cnt_q == C_LAST_SYNC) begin
                        state_q  <= RUN;
                        active_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q  <= RUN;
                    active_q <= 1'b1;
                end
                default: state_q <= SYNC;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_paralelo_serial_tx.sv
//==============================================================================
// Module   : tb_paralelo_serial_tx
// Brief    : Scoreboard bench for paralelo_serial_tx (per-edge expected queue).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_paralelo_serial_tx;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       active_out;

    paralelo_serial_tx #(
        .WIDTH      (8),
        .COMMA      (8'hBC),
        .SYNC_COUNT (4)
    ) dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .active_out (active_out)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic b;
        logic rdy;
        logic act;
        int   k;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         k        = 0;
    logic [7:0] cur      = 8'h00;

    task automatic chk(input string nm, input int idx, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%b required=%b", nm, idx, a, e);
        end
    endtask

    // Monitor: after each active edge, compare the line against the scoreboard.
    always @(posedge clk_32f) begin
        exp_t e;
        #1;
        if (reset_L === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data_out",   e.k, data_out,   e.b);
            chk("ready_out",  e.k, ready_out,  e.rdy);
            chk("active_out", e.k, active_out, e.act);
        end
    end

    // Drives one cycle from a negedge and records what the next edge must produce.
    task automatic tick(input logic v, input logic [7:0] d);
        exp_t e;
        valid_in = v;
        data_in  = d;
        if (k % 8 == 0) cur = (k >= 32 && v) ? d : COMMA;
        e.b   = cur[7 - (k % 8)];
        e.rdy = ((k + 1) >= 32) && (((k + 1) % 8) == 0);
        e.act = (k >= 24);
        e.k   = k;
        exp_q.push_back(e);
        k++;
        @(negedge clk_32f);
    endtask

    task automatic send(input logic v, input logic [7:0] d);
        repeat (8) tick(v, d);
    endtask

    task automatic release_reset();
        @(negedge clk_32f);
        reset_L = 1'b1;
        k       = 0;
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(negedge clk_32f);
        chk("rst_data_out",   -1, data_out,   1'b0);
        chk("rst_ready_out",  -1, ready_out,  1'b0);
        chk("rst_active_out", -1, active_out, 1'b0);

        // Preamble with 0xF2 offered from reset, then streaming words and gaps.
        release_reset();
        repeat (4) send(1'b1, 8'hF2);
        send(1'b1, 8'hF2);
        send(1'b1, 8'h15);
        send(1'b1, 8'hDD);
        send(1'b1, 8'h45);
        send(1'b1, 8'hAA);
        send(1'b0, 8'h00);
        send(1'b1, 8'h13);
        send(1'b0, 8'h00);
        send(1'b1, 8'hBC);
        send(1'b0, 8'h00);

        // Reset in the middle of the 0xF2 word, then a full preamble again.
        reset_L = 1'b0;
        @(negedge clk_32f);
        reset_L = 1'b1;
        k       = 0;
        repeat (4) send(1'b1, 8'hF2);
        repeat (4) tick(1'b1, 8'hF2);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_data_out",   36, data_out,   1'b0);
        chk("async_ready_out",  36, ready_out,  1'b0);
        chk("async_active_out", 36, active_out, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk_32f);
        release_reset();
        repeat (4) send(1'b1, 8'hF2);
        send(1'b1, 8'hF2);
        send(1'b0, 8'h00);

        @(posedge clk_32f);
        #2;
        chk("scoreboard_drained", k, (exp_q.size() == 0), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
